// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised circular-buffer sync FIFO with status flags; FIFO_FWFT_EN selects first-word fall-through
module param_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int D     = 4,
    parameter int AF_TH = D - 1,
    parameter int AE_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         in,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(D+1)-1:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(D - 1);

    logic [WIDTH-1:0] mem_q [D];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             overflow_q, underflow_q;
    logic             wr_ok, rd_ok;

    // Status flags are pure decodes of the registered occupancy
    assign full         = (cnt_q == CW'(D));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CW'(AF_TH));
    assign almost_empty = (cnt_q <= CW'(AE_TH));
    assign count        = cnt_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write at full only fits when the head word leaves on the same edge;
    // a read at empty is never served, even by a concurrent write
    assign wr_ok = write_en && (!full || read_en);
    assign rd_ok = read_en && !empty;

    // Next-state for pointers (explicit wrap so any depth works) and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Storage array; never reset, stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    // Pointer, occupancy and error-pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= write_en && full && !read_en;
            underflow_q <= read_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly from storage; zero while nothing is held
    assign out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] out_q;

    // Registered read port: data appears the cycle after an accepted read and holds otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= '0;
        end else if (rd_ok) begin
            out_q <= mem_q[rd_ptr_q];
        end
    end

    assign out = out_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for param_sync_fifo at D=4 and D=5
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       we = 1'b0, re = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       full, empty, af, ae, ovf, udf;
    logic [2:0] cnt;

    logic       we5 = 1'b0, re5 = 1'b0;
    logic [7:0] din5 = 8'h00;
    logic [7:0] dout5;
    logic       full5, empty5, af5, ae5, ovf5, udf5;
    logic [2:0] cnt5;

    param_sync_fifo #(.WIDTH(8), .D(4)) u_dut4 (
        .clk(clk), .rst(rst), .write_en(we), .in(din), .read_en(re), .out(dout),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .count(cnt), .overflow(ovf), .underflow(udf)
    );

    param_sync_fifo #(.WIDTH(8), .D(5)) u_dut5 (
        .clk(clk), .rst(rst), .write_en(we5), .in(din5), .read_en(re5), .out(dout5),
        .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
        .count(cnt5), .overflow(ovf5), .underflow(udf5)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp5_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitors: pop one expected word per read the DUT accepts
    logic fire4, fire5;
`ifdef FIFO_FWFT_EN
    always @(posedge clk) begin
        fire4 = rst && re && !empty;
        if (fire4) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd4_extra: got 0x%0h, expected no read", dout);
            end else begin
                logic [7:0] e4;
                e4 = exp_q.pop_front();
                if (dout !== e4) begin
                    n_err++;
                    $display("FAIL rd4_data: got 0x%0h, expected 0x%0h at %0t", dout, e4, $time);
                end
            end
        end
    end
    always @(posedge clk) begin
        fire5 = rst && re5 && !empty5;
        if (fire5) begin
            n_vec++;
            if (exp5_q.size() == 0) begin
                n_err++;
                $display("FAIL rd5_extra: got 0x%0h, expected no read", dout5);
            end else begin
                logic [7:0] e5;
                e5 = exp5_q.pop_front();
                if (dout5 !== e5) begin
                    n_err++;
                    $display("FAIL rd5_data: got 0x%0h, expected 0x%0h at %0t", dout5, e5, $time);
                end
            end
        end
    end
`else
    always @(posedge clk) begin
        fire4 = rst && re && !empty;
        if (fire4) begin
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd4_extra: got 0x%0h, expected no read", dout);
            end else begin
                logic [7:0] e4;
                e4 = exp_q.pop_front();
                if (dout !== e4) begin
                    n_err++;
                    $display("FAIL rd4_data: got 0x%0h, expected 0x%0h at %0t", dout, e4, $time);
                end
            end
        end
    end
    always @(posedge clk) begin
        fire5 = rst && re5 && !empty5;
        if (fire5) begin
            #1;
            n_vec++;
            if (exp5_q.size() == 0) begin
                n_err++;
                $display("FAIL rd5_extra: got 0x%0h, expected no read", dout5);
            end else begin
                logic [7:0] e5;
                e5 = exp5_q.pop_front();
                if (dout5 !== e5) begin
                    n_err++;
                    $display("FAIL rd5_data: got 0x%0h, expected 0x%0h at %0t", dout5, e5, $time);
                end
            end
        end
    end
`endif

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input int ec, input logic eo, input logic eu);
        @(negedge clk);
        we = w; din = d; re = r;
        @(posedge clk);
        #1;
        chk("count", 32'(cnt), 32'(ec));
        chk("flags", {28'd0, full, empty, af, ae},
            {28'd0, ec == 4, ec == 0, ec >= 3, ec <= 1});
        chk("overflow", 32'(ovf), 32'(eo));
        chk("underflow", 32'(udf), 32'(eu));
    endtask

    task automatic step5(input logic w, input logic [7:0] d, input logic r, input int ec);
        @(negedge clk);
        we5 = w; din5 = d; re5 = r;
        @(posedge clk);
        #1;
        chk("count5", 32'(cnt5), 32'(ec));
        chk("flags5", {28'd0, full5, empty5, af5, ae5},
            {28'd0, ec == 5, ec == 0, ec >= 4, ec <= 1});
    endtask

    task automatic do_reset(input logic busy);
        @(negedge clk);
        rst = 1'b0; we = busy; re = busy; din = 8'hAA;
        we5 = busy; re5 = busy; din5 = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_flags", {28'd0, full, empty, af, ae}, 32'b0101);
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_err", {30'd0, ovf, udf}, 32'd0);
        chk("rst_count5", 32'(cnt5), 32'd0);
        chk("rst_out5", 32'(dout5), 32'd0);
        @(negedge clk);
        rst = 1'b1; we = 1'b0; re = 1'b0; we5 = 1'b0; re5 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);
        do_reset(1'b1);

        // Fill to full, watching almost_full at 3 and full at 4
        step(1, 8'h11, 0, 1, 0, 0);
        step(1, 8'h22, 0, 2, 0, 0);
        step(1, 8'h33, 0, 3, 0, 0);
        step(1, 8'h44, 0, 4, 0, 0);
        // Dropped write at full
        step(1, 8'h55, 0, 4, 1, 0);
        step(0, 8'h00, 0, 4, 0, 0);
        // Drain: 0x55 must not appear
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        step(0, 8'h00, 1, 3, 0, 0);
        step(0, 8'h00, 1, 2, 0, 0);
        step(0, 8'h00, 1, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        // Read at empty is rejected and out holds
        step(0, 8'h00, 1, 0, 0, 1);
`ifdef FIFO_FWFT_EN
        chk("udf_out_hold", 32'(dout), 32'h00);
`else
        chk("udf_out_hold", 32'(dout), 32'h44);
`endif
        // Read+write at empty: write lands, read rejected
        step(1, 8'h66, 1, 1, 0, 1);
        exp_q.push_back(8'h66);
        step(0, 8'h00, 1, 0, 0, 0);

        // Refill, then 8 concurrent read+write cycles at full
        step(1, 8'hB0, 0, 1, 0, 0);
        step(1, 8'hB1, 0, 2, 0, 0);
        step(1, 8'hB2, 0, 3, 0, 0);
        step(1, 8'hB3, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 8; i++) step(1, 8'hA0 + 8'(i), 1, 4, 0, 0);
        for (int i = 4; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
        step(0, 8'h00, 1, 3, 0, 0);
        step(0, 8'h00, 1, 2, 0, 0);
        step(0, 8'h00, 1, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);

        // Mid-stream reset discards buffered words
        step(1, 8'hC1, 0, 1, 0, 0);
        step(1, 8'hC2, 0, 2, 0, 0);
        do_reset(1'b0);
        step(1, 8'hC3, 0, 1, 0, 0);
        exp_q.push_back(8'hC3);
        step(0, 8'h00, 1, 0, 0, 0);

        // Single write from empty
        step(1, 8'h77, 0, 1, 0, 0);
`ifdef FIFO_FWFT_EN
        chk("fwft_head", 32'(dout), 32'h77);
`endif
        exp_q.push_back(8'h77);
        step(0, 8'h00, 1, 0, 0, 0);
        @(negedge clk);
        we = 1'b0; re = 1'b0;

        // D=5: 12 writes interleaved with reads, pointers wrap 4->0
        step5(1, 8'h50, 0, 1);
        step5(1, 8'h51, 0, 2);
        step5(1, 8'h52, 0, 3);
        for (int i = 0; i < 12; i++) exp5_q.push_back(8'h50 + 8'(i));
        for (int i = 3; i < 12; i++) step5(1, 8'h50 + 8'(i), 1, 3);
        step5(0, 8'h00, 1, 2);
        step5(0, 8'h00, 1, 1);
        step5(0, 8'h00, 1, 0);
        @(negedge clk);
        we5 = 1'b0; re5 = 1'b0;
        @(negedge clk);

        chk("sb4_drained", 32'(exp_q.size()), 32'd0);
        chk("sb5_drained", 32'(exp5_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
